ext_load_pipe: RTL and testbench
================================

// Module: ext_load_pipe
// PURPOSE
//  Parametrised successor to the immediate extender: one unit for immediate (zero/sign/upper/branch)
//  and load-data (lb/lbu/lh/lhu/lw) extension. Results are buffered in a DEPTH-entry FIFO behind
//  valid/ready handshakes. Sits between DM read data / ID immediate field and the W-stage writeback
//  mux, and absorbs writeback stalls. Flags misaligned accesses and illegal ops instead of returning garbage.
// PARAMETERS
//  DATA_W  32  datapath width; multiple of 16, >= 32
//  IMM_W   16  immediate field width; < DATA_W
//  TAG_W   5   sideband tag carried with each entry (e.g. destination register number)
//  DEPTH   2   FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1               clock, rising edge
//  reset_n    in   1               asynchronous reset, active low
//  flush      in   1               synchronous pipeline flush; discards all entries
//  in_valid   in   1               input request valid
//  in_ready   out  1               input accepted when in_valid & in_ready
//  in_op      in   4               0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH, 4 LB, 5 LBU, 6 LH, 7 LHU, 8 LW
//  in_data    in   DATA_W          immediate (low IMM_W bits used) or loaded memory word
//  in_off     in   $clog2(DATA_W/8) byte offset of the access within the word
//  in_tag     in   TAG_W           passed through unchanged
//  out_valid  out  1               head entry valid
//  out_ready  in   1               consumer accepts the head entry when out_valid & out_ready
//  out_data   out  DATA_W          extended result
//  out_tag    out  TAG_W           tag of the head entry
//  out_exc    out  2               0 none, 1 misaligned, 2 illegal op
//  count      out  $clog2(DEPTH)+1 current occupancy
// BEHAVIOUR
//  - Reset (reset_n low, async): FIFO pointers and count = 0; all storage cleared to 0;
//    out_valid = 0; out_data/out_tag/out_exc = 0; in_ready = 0 while reset_n is low.
//  - Extension is combinational on the input. The result is written into the FIFO on accept.
//    Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N (if the FIFO was empty).
//    There is no combinational path from in_* to out_*.
//  - ZERO: {0, d[IMM_W-1:0]}. SIGN: sign-extend d[IMM_W-1:0].
//    UPPER: d[IMM_W-1:0] << (DATA_W-IMM_W), low bits 0. BRANCH: SIGN result << 2, with bits above DATA_W dropped.
//  - LB/LBU: byte = d[8*off +: 8]; sign- or zero-extended. Byte ops are never misaligned.
//  - LH/LHU: half = d[16*off[hi:1] +: 16]; off[0]=1 -> exc=1.
//  - LW: off != 0 -> exc=1; otherwise d unchanged.
//  - op >= 9 -> exc=2. Any exception sets out_data = 0, and the entry is still queued in order.
//  - in_ready = reset_n & (count < DEPTH). It does not depend on out_ready, so a full FIFO does not
//    accept an input in the same cycle as a pop.
//  - out_valid = (count != 0). out_* show the head entry and hold stable while out_valid & !out_ready.
//  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged.
//    Both pointers wrap modulo DEPTH.
//  - flush = 1 at an edge: count, rd_ptr and wr_ptr go to 0; a push or pop in the same cycle is discarded.
//    Flush has priority over all other events. Stored data need not be cleared.
//  - Async reset asserted mid-operation discards all entries immediately. out_valid falls without waiting for a clock.
// TESTING
//  1 Reset, then SIGN d=0x0000_8001 -> out 0xFFFF_8001 one cycle later. ZERO same d -> 0x0000_8001.
//    UPPER d=0x1234 -> 0x1234_0000. BRANCH d=0xFFFF -> 0xFFFF_FFFC.
//  2 d=0x80FF_7F01, LB off=0..3 -> 0x01, 0x7F, 0xFFFF_FFFF, 0xFFFF_FF80.
//    LBU off=3 -> 0x80. LH off=2 -> 0xFFFF_80FF. LHU off=2 -> 0x80FF.
//  3 LH off=1 -> exc=1, data 0. LW off=2 -> exc=1. op=12 -> exc=2. Each keeps its tag, in order.
//  4 Hold out_ready=0 and push 3 ops back-to-back -> in_ready falls after 2 accepts, count=2, head stable.
//    Then raise out_ready -> FIFO drains in order.
//  5 Streaming: in_valid=1, out_ready=1 for 10 cycles -> 1 result per cycle, count stays at 1,
//    pointers wrap with no loss or duplicate.
//  6 With count=2, pulse flush together with a push -> count=0, out_valid=0 next cycle.
//    Assert reset_n=0 between edges -> out_valid drops immediately.

Source files
------------

// File: rtl/ext_load_pipe_if.sv
// ---------------------------------------------------------------------------
// ext_load_pipe_if
//   Bundles the request and result handshakes of ext_load_pipe.
//   Parameters must match the ext_load_pipe instance they connect to.
//
//   Request side (producer -> pipe):
//     in_valid  request valid
//     in_ready  pipe can accept this cycle
//     in_op     extension/load opcode
//     in_data   immediate (low IMM_W bits) or loaded memory word
//     in_off    byte offset of the access within the word
//     in_tag    sideband tag carried with the entry
//   Result side (pipe -> consumer):
//     out_valid head entry valid
//     out_ready consumer takes the head entry
//     out_data  extended result
//     out_tag   tag of the head entry
//     out_exc   0 none, 1 misaligned, 2 illegal op
//     count     current FIFO occupancy
//
//   master: the surrounding datapath (drives requests, consumes results)
//   slave : the ext_load_pipe block itself
// ---------------------------------------------------------------------------
interface ext_load_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_exc;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_op, in_data, in_off, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_exc, count
  );

  modport slave (
    input  in_valid, in_op, in_data, in_off, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_exc, count
  );
endinterface

// File: rtl/ext_load_pipe.sv
// ---------------------------------------------------------------------------
// ext_load_pipe
//   Unified immediate / load-data extender with a DEPTH-entry result FIFO.
//   Each accepted request is extended combinationally and the result (data,
//   tag, exception code) is written into the FIFO, so results reach the
//   writeback mux one cycle after acceptance and writeback stalls are
//   absorbed by the buffer. Misaligned loads and unknown opcodes are reported
//   through out_exc with out_data forced to zero; they stay in program order.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous reset, active low; empties the FIFO immediately
//     flush    synchronous flush; discards every entry, wins over push/pop
//     bus      ext_load_pipe_if.slave (request and result handshakes)
//
//   Opcodes: 0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH, 4 LB, 5 LBU, 6 LH, 7 LHU, 8 LW
// ---------------------------------------------------------------------------
module ext_load_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  ext_load_pipe_if.slave bus
);

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BIDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [3:0] OP_ZERO   = 4'd0;
  localparam logic [3:0] OP_SIGN   = 4'd1;
  localparam logic [3:0] OP_UPPER  = 4'd2;
  localparam logic [3:0] OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_LB     = 4'd4;
  localparam logic [3:0] OP_LBU    = 4'd5;
  localparam logic [3:0] OP_LH     = 4'd6;
  localparam logic [3:0] OP_LHU    = 4'd7;
  localparam logic [3:0] OP_LW     = 4'd8;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd2;

  // Extension datapath signals
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sext;
  logic [BIDX_W-1:0] byte_idx;
  logic [BIDX_W-1:0] half_idx;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ext_data;
  logic [1:0]        ext_exc;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [1:0]        exc_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push;
  logic              pop;

  // Byte and halfword lanes are selected by bit index derived from the
  // offset; the halfword lane ignores off[0] (which only flags misalignment).
  assign imm      = bus.in_data[IMM_W-1:0];
  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign byte_idx = {bus.in_off, 3'b000};
  assign half_idx = {bus.in_off[OFF_W-1:1], 4'b0000};
  assign byte_v   = bus.in_data[byte_idx +: 8];
  assign half_v   = bus.in_data[half_idx +: 16];

  // Combinational extension of the current request. Any exception leaves
  // ext_data at zero so the consumer never sees partial garbage.
  always_comb begin
    ext_data = '0;
    ext_exc  = EXC_NONE;
    case (bus.in_op)
      OP_ZERO:   ext_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_SIGN:   ext_data = imm_sext;
      OP_UPPER:  ext_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_BRANCH: ext_data = {imm_sext[DATA_W-3:0], 2'b00};
      OP_LB:     ext_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      OP_LBU:    ext_data = {{(DATA_W-8){1'b0}}, byte_v};
      OP_LH: begin
        if (bus.in_off[0]) begin
          ext_exc = EXC_MISALIGN;
        end else begin
          ext_data = {{(DATA_W-16){half_v[15]}}, half_v};
        end
      end
      OP_LHU: begin
        if (bus.in_off[0]) begin
          ext_exc = EXC_MISALIGN;
        end else begin
          ext_data = {{(DATA_W-16){1'b0}}, half_v};
        end
      end
      OP_LW: begin
        if (bus.in_off != '0) begin
          ext_exc = EXC_MISALIGN;
        end else begin
          ext_data = bus.in_data;
        end
      end
      default:   ext_exc = EXC_ILLEGAL;
    endcase
  end

  // in_ready depends only on occupancy (and reset), never on out_ready, so a
  // full FIFO refuses a push even in a cycle where the head is popped.
  assign bus.in_ready = reset_n & (count_q < DEPTH_C);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = bus.out_valid & bus.out_ready;

  // FIFO state. Reset clears storage so out_* read as zero afterwards; flush
  // only rewinds the pointers and count and drops the same-cycle push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
        exc_mem[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= ext_data;
        tag_mem[wr_ptr]  <= bus.in_tag;
        exc_mem[wr_ptr]  <= ext_exc;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The head entry is read straight from storage; out_valid follows the
  // count, so an asynchronous reset drops it without a clock edge.
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = data_mem[rd_ptr];
  assign bus.out_tag   = tag_mem[rd_ptr];
  assign bus.out_exc   = exc_mem[rd_ptr];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_ext_load_pipe.sv
// ---------------------------------------------------------------------------
// tb_ext_load_pipe
//   Self-checking bench for ext_load_pipe (default parameters). A queue-based
//   model tracks the FIFO contents and an arithmetic reference computes each
//   extended result; outputs are compared every cycle on the falling edge.
//   Directed vectors with literal results pin both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_ext_load_pipe;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 2;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic [1:0]  exc;
  } entry_t;

  typedef struct {
    int          op;
    logic [31:0] d;
    int          off;
    logic [31:0] exp_data;
    logic [1:0]  exp_exc;
  } dir_t;

  logic clk;
  logic reset_n;
  logic flush;

  int total;
  int bad;

  entry_t q[$];
  dir_t   dirs[15];

  ext_load_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  ext_load_pipe #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .bus    (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check in the bench funnels through here.
  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension written as plain integer arithmetic.
  function automatic entry_t model_ext(input int op, input logic [31:0] din, input int off, input logic [4:0] tag);
    entry_t  e;
    longint  m;
    longint  d;
    longint  imm;
    longint  simm;
    longint  b;
    longint  h;
    m = 64'h0000_0000_FFFF_FFFF;
    d = longint'({32'd0, din});
    imm = d % 65536;
    simm = (imm >= 32768) ? imm - 65536 : imm;
    e.data = '0;
    e.exc = 2'd0;
    e.tag = tag;
    b = (d / (longint'(1) << (8 * off))) % 256;
    h = (d / (longint'(1) << (16 * (off / 2)))) % 65536;
    case (op)
      0: e.data = 32'(imm);
      1: e.data = 32'(simm & m);
      2: e.data = 32'((imm * 65536) & m);
      3: e.data = 32'((simm * 4) & m);
      4: e.data = 32'(((b >= 128) ? b - 256 : b) & m);
      5: e.data = 32'(b);
      6: if (off % 2 != 0) e.exc = 2'd1; else e.data = 32'(((h >= 32768) ? h - 65536 : h) & m);
      7: if (off % 2 != 0) e.exc = 2'd1; else e.data = 32'(h);
      8: if (off != 0) e.exc = 2'd1; else e.data = din;
      default: e.exc = 2'd2;
    endcase
    return e;
  endfunction

  task automatic apply_stimulus(input logic iv, input int op, input logic [31:0] d, input int off,
                                input logic [4:0] tag, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_op     = 4'(op);
    bus.in_data   = d;
    bus.in_off    = 2'(off);
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Compare every observable output against the model's view of the FIFO.
  task automatic check_output();
    compare("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
    compare("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    compare("count", 64'(bus.count), 64'(q.size()));
    if (q.size() != 0) begin
      compare("out_data", 64'(bus.out_data), 64'(q[0].data));
      compare("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
      compare("out_exc", 64'(bus.out_exc), 64'(q[0].exc));
    end
  endtask

  // One clock: advance the model at the rising edge from the driven inputs,
  // then check the DUT at the following falling edge.
  task automatic cycle();
    bit m_ready;
    bit m_valid;
    @(posedge clk);
    m_ready = (q.size() < DEPTH);
    m_valid = (q.size() != 0);
    if (flush) begin
      q.delete();
    end else begin
      if (m_valid && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && m_ready)
        q.push_back(model_ext(int'(bus.in_op), bus.in_data, int'(bus.in_off), bus.in_tag));
    end
    @(negedge clk);
    check_output();
  endtask

  initial begin
    entry_t e;
    total = 0;
    bad = 0;

    dirs = '{
      '{1,  32'h0000_8001, 0, 32'hFFFF_8001, 2'd0},
      '{0,  32'h0000_8001, 0, 32'h0000_8001, 2'd0},
      '{2,  32'h0000_1234, 0, 32'h1234_0000, 2'd0},
      '{3,  32'h0000_FFFF, 0, 32'hFFFF_FFFC, 2'd0},
      '{4,  32'h80FF_7F01, 0, 32'h0000_0001, 2'd0},
      '{4,  32'h80FF_7F01, 1, 32'h0000_007F, 2'd0},
      '{4,  32'h80FF_7F01, 2, 32'hFFFF_FFFF, 2'd0},
      '{4,  32'h80FF_7F01, 3, 32'hFFFF_FF80, 2'd0},
      '{5,  32'h80FF_7F01, 3, 32'h0000_0080, 2'd0},
      '{6,  32'h80FF_7F01, 2, 32'hFFFF_80FF, 2'd0},
      '{7,  32'h80FF_7F01, 2, 32'h0000_80FF, 2'd0},
      '{6,  32'h80FF_7F01, 1, 32'h0000_0000, 2'd1},
      '{8,  32'h80FF_7F01, 2, 32'h0000_0000, 2'd1},
      '{12, 32'h80FF_7F01, 0, 32'h0000_0000, 2'd2},
      '{8,  32'h80FF_7F01, 0, 32'h80FF_7F01, 2'd0}
    };

    // Reset state while reset_n is held low
    reset_n = 1'b0;
    apply_stimulus(1'b0, 0, 32'd0, 0, 5'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    compare("reset_out_valid", 64'(bus.out_valid), 64'd0);
    compare("reset_in_ready", 64'(bus.in_ready), 64'd0);
    compare("reset_count", 64'(bus.count), 64'd0);
    compare("reset_out_data", 64'(bus.out_data), 64'd0);
    compare("reset_out_tag", 64'(bus.out_tag), 64'd0);
    compare("reset_out_exc", 64'(bus.out_exc), 64'd0);
    reset_n = 1'b1;

    // Directed vectors streamed with out_ready high: the head after each
    // edge is the vector just pushed, so it is checked against its literal.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1, dirs[i].op, dirs[i].d, dirs[i].off, 5'(i + 1), 1'b1, 1'b0);
      e = model_ext(dirs[i].op, dirs[i].d, dirs[i].off, 5'(i + 1));
      compare($sformatf("model_pin_%0d", i), 64'(e.data), 64'(dirs[i].exp_data));
      cycle();
      compare($sformatf("dir_data_%0d", i), 64'(bus.out_data), 64'(dirs[i].exp_data));
      compare($sformatf("dir_exc_%0d", i), 64'(bus.out_exc), 64'(dirs[i].exp_exc));
      compare($sformatf("dir_tag_%0d", i), 64'(bus.out_tag), 64'(i + 1));
    end
    apply_stimulus(1'b0, 0, 32'd0, 0, 5'd0, 1'b1, 1'b0);
    cycle();
    compare("drain_count", 64'(bus.count), 64'd0);

    // Backpressure: three back-to-back pushes with out_ready low
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1, 32'h0000_0100 + 32'(i), 0, 5'(20 + i), 1'b0, 1'b0);
      cycle();
    end
    compare("full_count", 64'(bus.count), 64'd2);
    compare("full_in_ready", 64'(bus.in_ready), 64'd0);
    compare("full_head_tag", 64'(bus.out_tag), 64'd20);
    compare("full_head_data", 64'(bus.out_data), 64'h0000_0100);
    apply_stimulus(1'b0, 0, 32'd0, 0, 5'd0, 1'b1, 1'b0);
    cycle();
    compare("drain1_tag", 64'(bus.out_tag), 64'd21);
    cycle();
    compare("drained_valid", 64'(bus.out_valid), 64'd0);

    // Streaming: one result per cycle, occupancy steady at one
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 5, $urandom, $urandom_range(0, 3), 5'(i), 1'b1, 1'b0);
      cycle();
      compare("stream_count", 64'(bus.count), 64'd1);
      compare("stream_tag", 64'(bus.out_tag), 64'(i));
    end
    apply_stimulus(1'b0, 0, 32'd0, 0, 5'd0, 1'b1, 1'b0);
    cycle();

    // Flush with a simultaneous push while full
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 0, $urandom, 0, 5'(i), 1'b0, 1'b0);
      cycle();
    end
    apply_stimulus(1'b1, 0, 32'h1234, 0, 5'd9, 1'b1, 1'b1);
    cycle();
    compare("flush_count", 64'(bus.count), 64'd0);
    compare("flush_out_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset between edges empties the FIFO immediately
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 8, $urandom, 0, 5'(i), 1'b0, 1'b0);
      cycle();
    end
    apply_stimulus(1'b0, 0, 32'd0, 0, 5'd0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    compare("async_out_valid", 64'(bus.out_valid), 64'd0);
    compare("async_count", 64'(bus.count), 64'd0);
    compare("async_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      apply_stimulus(1'($urandom_range(0, 1)), op, $urandom, int'($urandom_range(0, 3)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 31) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
